crc_accum_goback: RTL and testbench

- Downstream stage of the per-beat LUT CRC pipeline.
- Consumes one 32-bit partial CRC per bus beat, already init-XORed on the SOP beat, plus aligned sop/eop/dval/mod/packet_num sideband.
- Chains beats of a packet into one CRC, then applies "goback" correction to remove the zero padding of the last partial beat.
- Applies the final XOR and emits one CRC per packet, fully pipelined at one packet-end per cycle.

---
 rtl/crc_accum_goback.sv | 243 ++++++++++++++++++++++++
 tb/tb_crc_accum_goback.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_accum_goback.sv
// crc_accum_goback
// Chains per-beat partial CRC-32 values of a packet into one CRC. The zero
// padding of the final partial beat is then removed by a "goback" pipeline,
// the final XOR is applied, and one CRC is emitted per packet end. Throughput
// is one packet end per cycle, with no stalls.
//
// Optional feature macro: CRC_CHECK_EN. When defined, it adds the
// CHECK_RESIDUE parameter and the crc_ok output. crc_ok flags a corrected CRC
// that equals the good-frame residue.
//
// adv (advance by BUS_WIDTH bit times) and back (retreat by 8*2^k bit times)
// are multiplications by fixed elements of GF(2)[x]/LUT_POLY. Each is folded
// into a constant 32x32 XOR matrix at elaboration. The matrices are built
// from x^BUS_WIDTH and x^-(8*2^k), computed by square-and-multiply. x^-1 is
// {1, LUT_POLY[31:1]}, because LUT_POLY has its constant term set.
module crc_accum_goback #(
   parameter int          BUS_WIDTH = 1024,
   parameter int          MOD_WIDTH = 7,
   parameter logic [31:0] LUT_POLY  = 32'h04C11DB7,
   parameter logic [31:0] FINAL_XOR = 32'hFFFFFFFF
`ifdef CRC_CHECK_EN
   ,
   parameter logic [31:0] CHECK_RESIDUE = 32'hC704DD7B
`endif
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 sop_in,
   input  logic                 eop_in,
   input  logic                 dval_in,
   input  logic [3:0]           packet_num_in,
   input  logic [MOD_WIDTH-1:0] mod_in,
   input  logic [31:0]          din,
   output logic                 crc_vld,
   output logic [31:0]          crc_out,
   output logic [3:0]           packet_num_out,
   output logic                 err_sop
`ifdef CRC_CHECK_EN
   ,
   output logic                 crc_ok
`endif
);

   typedef logic [1023:0]                mat_t;
   typedef logic [MOD_WIDTH-1:0][1023:0] mat_set_t;
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} state_t;

   // Carry-less multiply of two field elements, reduced modulo LUT_POLY.
   function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      logic [63:0] poly_full;
      prod      = 64'd0;
      poly_full = {31'd0, 1'b1, LUT_POLY};
      for (int i = 0; i < 32; i++) begin
         prod = prod ^ (({32'd0, a} << i) & {64{b[i]}});
      end
      for (int i = 63; i >= 32; i--) begin
         prod = prod ^ ((poly_full << (i - 32)) & {64{prod[i]}});
      end
      return prod[31:0];
   endfunction

   // base^n in the field, by square-and-multiply.
   function automatic logic [31:0] gf_pow(input logic [31:0] base, input int unsigned n);
      logic [31:0] res;
      logic [31:0] sq;
      res = 32'd1;
      sq  = base;
      for (int i = 0; i < 32; i++) begin
         res = n[i] ? gf_mul(res, sq) : res;
         sq  = gf_mul(sq, sq);
      end
      return res;
   endfunction

   // XOR matrix for "multiply by m"; column i is the image of bit i.
   function automatic mat_t build_mat(input logic [31:0] m);
      mat_t mat;
      mat = {1024{1'b0}};
      for (int col = 0; col < 32; col++) begin
         mat[col*32 +: 32] = gf_mul(32'd1 << col, m);
      end
      return mat;
   endfunction

   // One matrix per goback stage: stage k retreats by 8*2^k bit times.
   function automatic mat_set_t build_back_set();
      mat_set_t set;
      for (int k = 0; k < MOD_WIDTH; k++) begin
         set[k] = build_mat(gf_pow({1'b1, LUT_POLY[31:1]}, 32'd8 << k));
      end
      return set;
   endfunction

   // Apply a constant XOR matrix to a 32-bit value.
   function automatic logic [31:0] mat_apply(input mat_t mat, input logic [31:0] v);
      logic [31:0] res;
      res = 32'd0;
      for (int i = 0; i < 32; i++) begin
         res = res ^ (mat[i*32 +: 32] & {32{v[i]}});
      end
      return res;
   endfunction

   localparam mat_t     ADV_MAT  = build_mat(gf_pow(32'h00000002, BUS_WIDTH));
   localparam mat_set_t BACK_SET = build_back_set();

   state_t                state_r;
   state_t                state_nxt_s;
   logic [31:0]           acc_r;
   logic [31:0]           acc_nxt_s;
   logic [31:0]           adv_s;
   logic [31:0]           f_s;
   logic                  end_s;
   logic                  err_s;
   logic [MOD_WIDTH-1:0]  pad_s;

   logic [MOD_WIDTH:0]    stg_vld_r;
   logic [31:0]           stg_crc_r [0:MOD_WIDTH];
   logic [3:0]            stg_tag_r [0:MOD_WIDTH];
   logic [MOD_WIDTH-1:0]  stg_pad_r [0:MOD_WIDTH-1];

   assign adv_s = mat_apply(ADV_MAT, acc_r);
   // Padding bytes = -mod modulo the bytes per beat; mod 0 means a full beat.
   assign pad_s = {MOD_WIDTH{1'b0}} - mod_in;

   // Accumulator FSM: next state, chained CRC, end-of-packet and protocol error.
   always_comb begin
      state_nxt_s = state_r;
      acc_nxt_s   = acc_r;
      end_s       = 1'b0;
      err_s       = 1'b0;
      f_s         = din ^ adv_s;
      case (state_r)
         ST_IDLE: begin
            if (dval_in && sop_in) begin
               acc_nxt_s = din;
               f_s       = din;
               if (eop_in) begin
                  end_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_IN_PKT;
               end
            end else if (dval_in) begin
               err_s = 1'b1;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_IN_PKT: begin
            if (dval_in && sop_in) begin
               // Missing eop: abandon the old packet and restart on this beat.
               acc_nxt_s = din;
               f_s       = din;
               err_s     = 1'b1;
               if (eop_in) begin
                  end_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_IN_PKT;
               end
            end else if (dval_in) begin
               acc_nxt_s = din ^ adv_s;
               if (eop_in) begin
                  end_s       = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_IN_PKT;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            acc_nxt_s   = acc_r;
         end
      endcase
   end

   // Accumulator state and running CRC registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         acc_r   <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         acc_r   <= acc_nxt_s;
      end
   end

   // Valid bits of stage 0 and of the goback stages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_vld_r <= {(MOD_WIDTH+1){1'b0}};
      end else begin
         stg_vld_r <= {stg_vld_r[MOD_WIDTH-1:0], end_s};
      end
   end

   // Goback data path. Stage k+1 retreats 8*2^k bits when pad bit k is set.
   // The pad value shifts right so that bit 0 always selects the current stage.
   always_ff @(posedge clk) begin
      stg_crc_r[0] <= f_s;
      stg_tag_r[0] <= packet_num_in;
      stg_pad_r[0] <= pad_s;
      for (int k = 0; k < MOD_WIDTH; k++) begin
         stg_crc_r[k+1] <= stg_pad_r[k][0] ? mat_apply(BACK_SET[k], stg_crc_r[k]) : stg_crc_r[k];
         stg_tag_r[k+1] <= stg_tag_r[k];
      end
      for (int k = 0; k < MOD_WIDTH - 1; k++) begin
         stg_pad_r[k+1] <= stg_pad_r[k] >> 1;
      end
   end

   // Registered outputs: final XOR, tag, valid pulse and the error pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_vld        <= 1'b0;
         crc_out        <= 32'd0;
         packet_num_out <= 4'd0;
         err_sop        <= 1'b0;
      end else begin
         crc_vld        <= stg_vld_r[MOD_WIDTH];
         crc_out        <= stg_crc_r[MOD_WIDTH] ^ FINAL_XOR;
         packet_num_out <= stg_tag_r[MOD_WIDTH];
         err_sop        <= err_s;
      end
   end

`ifdef CRC_CHECK_EN
   // Good-frame flag, aligned with crc_vld and held low between packets.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         crc_ok <= 1'b0;
      end else begin
         crc_ok <= stg_vld_r[MOD_WIDTH] && (stg_crc_r[MOD_WIDTH] == CHECK_RESIDUE);
      end
   end
`endif

endmodule

// File: tb/tb_crc_accum_goback.sv
`timescale 1ns/1ps
// Bench for crc_accum_goback: a default 1024-bit instance (A) and a 32-bit
// instance (B). Expected CRCs come from constants and from a bit-serial model
// that follows the shift/unshift definitions directly.
module tb_crc_accum_goback;
   localparam int          BW_A    = 1024;
   localparam int          MW_A    = 7;
   localparam int          BW_B    = 32;
   localparam int          MW_B    = 2;
   localparam logic [31:0] POLY    = 32'h04C11DB7;
   localparam logic [31:0] FXOR    = 32'hFFFFFFFF;
   localparam logic [31:0] RESIDUE = 32'hC704DD7B;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        a_sop, a_eop, a_dval, a_vld, a_err;
   logic [3:0]  a_tag, a_tag_o;
   logic [6:0]  a_mod;
   logic [31:0] a_din, a_crc;
   logic        b_sop, b_eop, b_dval, b_vld, b_err;
   logic [3:0]  b_tag, b_tag_o;
   logic [1:0]  b_mod;
   logic [31:0] b_din, b_crc;
`ifdef CRC_CHECK_EN
   logic        a_ok, b_ok;
`endif

   crc_accum_goback u_a (
      .clk(clk), .rst(rst), .sop_in(a_sop), .eop_in(a_eop), .dval_in(a_dval),
      .packet_num_in(a_tag), .mod_in(a_mod), .din(a_din),
      .crc_vld(a_vld), .crc_out(a_crc), .packet_num_out(a_tag_o), .err_sop(a_err)
`ifdef CRC_CHECK_EN
      , .crc_ok(a_ok)
`endif
   );

   crc_accum_goback #(.BUS_WIDTH(BW_B), .MOD_WIDTH(MW_B)) u_b (
      .clk(clk), .rst(rst), .sop_in(b_sop), .eop_in(b_eop), .dval_in(b_dval),
      .packet_num_in(b_tag), .mod_in(b_mod), .din(b_din),
      .crc_vld(b_vld), .crc_out(b_crc), .packet_num_out(b_tag_o), .err_sop(b_err)
`ifdef CRC_CHECK_EN
      , .crc_ok(b_ok)
`endif
   );

   typedef struct {
      logic [31:0] crc;
      logic [3:0]  tag;
      logic        ok;
      int          cyc;
   } exp_t;

   typedef struct {
      logic [31:0] din;
      logic [6:0]  mod;
      logic [3:0]  tag;
      logic [31:0] exp;
   } vec_t;

   exp_t        qa[$];
   exp_t        qb[$];
   int          total = 0;
   int          bad = 0;
   int          cyc = 0;
   int          a_err_cnt = 0;
   int          exp_err_a = 0;
   int          ma_in = 0;
   logic [31:0] ma_acc = 32'd0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h want %08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference shift by one bit time (multiply by x) and its inverse.
   function automatic logic [31:0] m_fwd1(input logic [31:0] c);
      return {c[30:0], 1'b0} ^ (c[31] ? POLY : 32'd0);
   endfunction

   function automatic logic [31:0] m_back1(input logic [31:0] c);
      logic [31:0] t;
      t = c ^ (c[0] ? POLY : 32'd0);
      return {c[0], t[31:1]};
   endfunction

   function automatic logic [31:0] m_chain(input logic [31:0] acc, input logic [31:0] d, input int bw);
      logic [31:0] c;
      c = acc;
      for (int n = 0; n < bw; n++) c = m_fwd1(c);
      return c ^ d;
   endfunction

   // Corrected (pre-final-XOR) CRC after removing the padding bytes.
   function automatic logic [31:0] m_correct(input logic [31:0] f, input int md, input int bw);
      logic [31:0] c;
      int          nbytes;
      int          pad;
      nbytes = bw / 8;
      pad    = (nbytes - md) % nbytes;
      c      = f;
      for (int n = 0; n < 8 * pad; n++) c = m_back1(c);
      return c;
   endfunction

   // Monitor for instance A: each pulse must match the oldest pending packet.
   always @(negedge clk) begin
      if (a_err) a_err_cnt++;
      if (a_vld) begin
         if (qa.size() == 0) begin
            check("a_vld_without_packet", {31'd0, a_vld}, 32'd0);
         end else begin
            exp_t e;
            e = qa.pop_front();
            check("a_crc", a_crc, e.crc);
            check("a_tag", {28'd0, a_tag_o}, {28'd0, e.tag});
            check("a_latency", 32'(cyc), 32'(e.cyc));
`ifdef CRC_CHECK_EN
            check("a_crc_ok", {31'd0, a_ok}, {31'd0, e.ok});
`endif
         end
      end
   end

   // Monitor for instance B.
   always @(negedge clk) begin
      if (b_vld) begin
         if (qb.size() == 0) begin
            check("b_vld_without_packet", {31'd0, b_vld}, 32'd0);
         end else begin
            exp_t e;
            e = qb.pop_front();
            check("b_crc", b_crc, e.crc);
            check("b_tag", {28'd0, b_tag_o}, {28'd0, e.tag});
            check("b_latency", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic put_a(input logic sop, input logic eop, input logic dval, input logic [6:0] md, input logic [3:0] tag, input logic [31:0] d);
      a_sop = sop; a_eop = eop; a_dval = dval; a_mod = md; a_tag = tag; a_din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic put_b(input logic sop, input logic eop, input logic dval, input logic [3:0] tag, input logic [31:0] d);
      b_sop = sop; b_eop = eop; b_dval = dval; b_mod = 2'd0; b_tag = tag; b_din = d;
      @(posedge clk);
      #1;
   endtask

   task automatic push_a(input logic [31:0] corrected, input logic [3:0] tag);
      exp_t e;
      e.crc = corrected ^ FXOR;
      e.tag = tag;
      e.ok  = (corrected == RESIDUE);
      e.cyc = cyc + MW_A + 2;
      qa.push_back(e);
   endtask

   // Drive one beat on A; the packet-level model predicts outputs and errors.
   task automatic drive_a(input logic sop, input logic eop, input logic dval, input logic [6:0] md, input logic [3:0] tag, input logic [31:0] d);
      if (dval) begin
         if (sop) begin
            if (ma_in != 0) exp_err_a++;
            ma_acc = d;
            ma_in  = 1;
         end else if (ma_in == 0) begin
            exp_err_a++;
         end else begin
            ma_acc = m_chain(ma_acc, d, BW_A);
         end
         if (eop && ma_in != 0) begin
            push_a(m_correct(ma_acc, int'(md), BW_A), tag);
            ma_in = 0;
         end
      end
      put_a(sop, eop, dval, md, tag, d);
   endtask

   task automatic idle_a(input int n);
      for (int i = 0; i < n; i++) drive_a(1'($urandom), 1'($urandom), 1'b0, 7'($urandom), 4'($urandom), $urandom);
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      check("a_pending_after_drain", 32'(qa.size()), 32'd0);
      check("b_pending_after_drain", 32'(qb.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl[10];
      exp_t eb;
      int   len;

      a_sop = 1'b0; a_eop = 1'b0; a_dval = 1'b0; a_tag = 4'd0; a_mod = 7'd0; a_din = 32'd0;
      b_sop = 1'b0; b_eop = 1'b0; b_dval = 1'b0; b_tag = 4'd0; b_mod = 2'd0; b_din = 32'd0;
      #2 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_a_vld", {31'd0, a_vld}, 32'd0);
      check("rst_a_crc", a_crc, 32'd0);
      check("rst_a_tag", {28'd0, a_tag_o}, 32'd0);
      check("rst_a_err", {31'd0, a_err}, 32'd0);
      check("rst_b_vld", {31'd0, b_vld}, 32'd0);
      check("rst_b_crc", b_crc, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Back-to-back single-beat packets with constant expectations.
      tbl[0] = '{din: 32'h12345678, mod: 7'd0,   tag: 4'd9, exp: 32'hEDCBA987};
      tbl[1] = '{din: 32'h80000000, mod: 7'd127, tag: 4'd8, exp: 32'hFF7FFFFF};
      for (int i = 0; i < 8; i++) tbl[2+i] = '{din: 32'd0, mod: 7'd0, tag: 4'(i), exp: 32'hFFFFFFFF};
      for (int i = 0; i < 10; i++) begin
         eb.crc = tbl[i].exp;
         eb.tag = tbl[i].tag;
         eb.ok  = ((tbl[i].exp ^ FXOR) == RESIDUE);
         eb.cyc = cyc + MW_A + 2;
         qa.push_back(eb);
         put_a(1'b1, 1'b1, 1'b1, tbl[i].mod, tbl[i].tag, tbl[i].din);
      end
      put_a(1'b0, 1'b0, 1'b0, 7'd0, 4'd0, 32'd0);
      drain();

      // Two-beat packet on the 32-bit instance, then again with a gap cycle.
      for (int g = 0; g < 2; g++) begin
         put_b(1'b1, 1'b0, 1'b1, 4'd3, 32'h00000001);
         if (g == 1) put_b(1'b0, 1'b0, 1'b0, 4'd0, 32'hDEADBEEF);
         eb.crc = 32'hFB3EE248;
         eb.tag = 4'(3 + g);
         eb.ok  = 1'b0;
         eb.cyc = cyc + MW_B + 2;
         qb.push_back(eb);
         put_b(1'b0, 1'b1, 1'b1, 4'(3 + g), 32'h00000000);
         put_b(1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      end
      drain();

      // Missing eop: only the restarted packet produces a CRC.
      drive_a(1'b1, 1'b0, 1'b1, 7'd0, 4'd1, 32'hA5A5A5A5);
      drive_a(1'b1, 1'b0, 1'b1, 7'd0, 4'd2, 32'h0F0F1234);
      check("err_pulse_missing_eop", {31'd0, a_err}, 32'd1);
      drive_a(1'b0, 1'b0, 1'b1, 7'd0, 4'd2, 32'h11112222);
      drive_a(1'b0, 1'b1, 1'b1, 7'd5, 4'd2, 32'h33334444);
      check("err_clear_after_pulse", {31'd0, a_err}, 32'd0);
      // Beat without sop while idle is dropped.
      drive_a(1'b0, 1'b1, 1'b1, 7'd0, 4'd7, 32'h55556666);
      check("err_pulse_idle", {31'd0, a_err}, 32'd1);
      idle_a(2);
      drain();
      check("err_count", 32'(a_err_cnt), 32'(exp_err_a));

      // Randomized well-formed packets with idle gaps, against the model.
      for (int p = 0; p < 60; p++) begin
         len = int'($urandom_range(1, 4));
         for (int b = 0; b < len; b++) begin
            if ($urandom_range(0, 3) == 0) idle_a(1);
            drive_a(b == 0, b == len - 1, 1'b1, 7'($urandom_range(0, 127)), 4'($urandom), $urandom);
         end
      end
      idle_a(1);
      drain();
      check("err_count_random", 32'(a_err_cnt), 32'(exp_err_a));

`ifdef CRC_CHECK_EN
      // A frame whose corrected CRC equals the residue is flagged good.
      drive_a(1'b1, 1'b1, 1'b1, 7'd0, 4'd12, RESIDUE);
      idle_a(1);
      drain();
`endif

      // Reset while a packet is in the goback pipe and another is in progress.
      drive_a(1'b1, 1'b1, 1'b1, 7'd3, 4'd10, 32'hCAFEF00D);
      drive_a(1'b1, 1'b0, 1'b1, 7'd0, 4'd11, 32'h01020304);
      idle_a(1);
      rst = 1'b1;
      #1;
      qa.delete();
      qb.delete();
      ma_in = 0;
      check("midrst_a_vld", {31'd0, a_vld}, 32'd0);
      check("midrst_a_crc", a_crc, 32'd0);
      check("midrst_a_tag", {28'd0, a_tag_o}, 32'd0);
      check("midrst_a_err", {31'd0, a_err}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle_a(MW_A + 6);
      // Continuation beat after reset is an error, not part of the old packet.
      drive_a(1'b0, 1'b1, 1'b1, 7'd0, 4'd11, 32'h99999999);
      idle_a(2);
      drive_a(1'b1, 1'b1, 1'b1, 7'd64, 4'd13, 32'h0BADC0DE);
      idle_a(1);
      drain();
      check("err_count_after_rst", 32'(a_err_cnt), 32'(exp_err_a));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
